// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } chan_state_e;

    localparam int DEF_N_CH          = 2;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_DB_CYCLES     = 1_000_000;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus: raw inputs and repeat enables in, conditioned events out.
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] hold_level;
    logic [N_CH-1:0] repeat_pulse;
    logic            any_press;

    modport master (
        output btn_in, repeat_en,
        input  btn_level, press_pulse, release_pulse, hold_level, repeat_pulse, any_press
    );

    modport slave (
        input  btn_in, repeat_en,
        output btn_level, press_pulse, release_pulse, hold_level, repeat_pulse, any_press
    );
endinterface

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce FSM, hold and auto-repeat counters.
module btn_chan
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic repeat_o,
    output logic press_d_o
);
    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    chan_state_e            state_q, state_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                   level_q, level_d;
    logic                   hold_q, hold_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;
    logic                   run_hold;

    assign s = sync_q[SYNC_STAGES-1];

    // Register the synchroniser chain, FSM state, counters and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= RELEASED;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            hold_q     <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_i};
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            hold_q     <= hold_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    // Debounce transitions plus hold/repeat timing; the release-accept cycle
    // skips hold processing so release never coincides with a repeat.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        level_d    = level_q;
        hold_d     = hold_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        run_hold   = 1'b0;

        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                run_hold = 1'b1;
                if (!s) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end
            end
            DB_RELEASE: begin
                if (s) begin
                    state_d  = PRESSED;
                    run_hold = 1'b1;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    hold_d    = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                    run_hold = 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase

        if (run_hold) begin
            if (hold_cnt_q != HOLD_SAT) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (hold_cnt_q == HOLD_LAST) begin
                hold_d    = 1'b1;
                rep_cnt_d = '0;
                repeat_d  = repeat_en_i;
            end else if (hold_q) begin
                if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = '0;
                    repeat_d  = repeat_en_i;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;
    assign repeat_o  = repeat_q;
    assign press_d_o = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: one btn_chan per channel plus any_press.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    btn_conditioner_if.slave         bus
);
    logic [N_CH-1:0] press_nxt;
    logic            any_press_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_i      (bus.btn_in[i]),
            .repeat_en_i(bus.repeat_en[i]),
            .level_o    (bus.btn_level[i]),
            .press_o    (bus.press_pulse[i]),
            .release_o  (bus.release_pulse[i]),
            .hold_o     (bus.hold_level[i]),
            .repeat_o   (bus.repeat_pulse[i]),
            .press_d_o  (press_nxt[i])
        );
    end

    // Register the OR of next-cycle press pulses so it aligns with press_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_nxt;
        end
    end

    assign bus.any_press = any_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (N_CH=2, SYNC=2, DB=4, HOLD=20, REPEAT=8).
module tb_btn_conditioner;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    btn_conditioner_if #(.N_CH(2)) bus ();

    btn_conditioner #(
        .N_CH         (2),
        .SYNC_STAGES  (2),
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                       input logic [1:0] rel, input logic [1:0] hld, input logic [1:0] rep,
                       input logic any);
        logic [10:0] obs;
        logic [10:0] expv;
        obs  = {bus.btn_level, bus.press_pulse, bus.release_pulse,
                bus.hold_level, bus.repeat_pulse, bus.any_press};
        expv = {lvl, prs, rel, hld, rep, any};
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (lvl,prs,rel,hld,rep,any)", tag, obs, expv);
        end
    endtask

    initial begin
        logic hexp;
        logic rexp;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.btn_in    = 2'b00;
        bus.repeat_en = 2'b00;

        // Reset state
        tick(2);
        chk("reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        tick(3);
        chk("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // Clean press on ch0, held 10 cycles, then released
        bus.btn_in = 2'b01;
        tick(6);
        chk("press0_early", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("press0_pulse", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        tick(1);
        chk("press0_level", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(2);
        bus.btn_in = 2'b00;
        tick(6);
        chk("rel0_early", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("rel0_pulse", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("rel0_after", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // 3-cycle glitch on ch1 is rejected
        bus.btn_in = 2'b10;
        tick(3);
        bus.btn_in = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("glitch1_c%0d", i), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        end

        // 2-cycle bounce low during a ch1 press is rejected
        bus.btn_in = 2'b10;
        tick(7);
        chk("press1_pulse", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
        tick(2);
        bus.btn_in = 2'b00;
        tick(2);
        bus.btn_in = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("bounce1_c%0d", i), 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        bus.btn_in = 2'b00;
        tick(6);
        chk("rel1_early", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("rel1_pulse", 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        tick(2);

        // Long hold on ch0 with auto-repeat enabled, released after 60 cycles
        bus.repeat_en = 2'b01;
        bus.btn_in    = 2'b01;
        tick(7);
        chk("hold_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        for (int j = 1; j <= 67; j++) begin
            tick(1);
            if (j == 67) begin
                chk("hold_release", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
            end else begin
                hexp = (j >= 20);
                rexp = (j >= 20) && (((j - 20) % 8) == 0);
                chk($sformatf("hold_rep_c%0d", j), 2'b01, 2'b00, 2'b00,
                    {1'b0, hexp}, {1'b0, rexp}, 1'b0);
            end
            if (j == 60) bus.btn_in = 2'b00;
        end
        tick(1);
        chk("hold_after", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        // Hold with repeat disabled, then enabled live at cycle 30
        bus.repeat_en = 2'b00;
        bus.btn_in    = 2'b01;
        tick(7);
        chk("norep_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            hexp = (j >= 20);
            rexp = (j == 36);
            chk($sformatf("norep_c%0d", j), 2'b01, 2'b00, 2'b00,
                {1'b0, hexp}, {1'b0, rexp}, 1'b0);
            if (j == 30) bus.repeat_en = 2'b01;
        end

        // Asynchronous reset while held with hold_level high
        rst_n = 1'b0;
        #1;
        chk("async_reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(3);
        chk("reset_no_release", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        tick(6);
        chk("requal_early", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("requal_press", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
        bus.btn_in = 2'b00;
        tick(7);
        chk("requal_release", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        tick(2);

        // Both channels pressed and released in the same cycle
        bus.btn_in = 2'b11;
        tick(6);
        chk("both_early", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("both_press", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
        tick(1);
        chk("both_level", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        bus.btn_in = 2'b00;
        tick(7);
        chk("both_release", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        tick(1);
        chk("both_after", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
